// File: rtl/lane_fifo_bank_pkg.sv
// Shared types and helpers for the lane FIFO bank: lane tag type and pointer sizing.
package lane_fifo_bank_pkg;

  localparam int unsigned LANE_TAG_WIDTH = 4;

  typedef logic [LANE_TAG_WIDTH-1:0] lane_tag_t;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  function automatic int unsigned ptr_width(int unsigned entries);
    return $clog2(entries) + 1;
  endfunction

endpackage

// File: rtl/lane_fifo.sv
// Single synchronous FIFO lane with enq, deq and flush; flush overrides both enq and deq.
module lane_fifo
  import lane_fifo_bank_pkg::*;
#(
  parameter int unsigned width = 16,
  parameter int unsigned depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             enq_i,
  input  logic [width-1:0] data_i,
  input  logic             deq_i,
  input  logic             flush_i,
  output logic             full_o,
  output logic             empty_o,
  output logic [width-1:0] first_o
);

  localparam int unsigned PtrW  = ptr_width(depth);
  localparam int unsigned AddrW = PtrW - 1;

  logic [PtrW-1:0]  rd_q, rd_d, wr_q, wr_d;
  logic [width-1:0] mem_q [depth];
  logic             enq_ok, deq_ok;

  assign empty_o = (rd_q == wr_q);
  assign full_o  = (rd_q[AddrW-1:0] == wr_q[AddrW-1:0]) && (rd_q[PtrW-1] != wr_q[PtrW-1]);
  assign first_o = mem_q[rd_q[AddrW-1:0]];

  assign enq_ok = enq_i && !full_o && !flush_i;
  assign deq_ok = deq_i && !empty_o;

  always_comb begin
    rd_d = rd_q;
    wr_d = wr_q;
    if (flush_i) begin
      rd_d = wr_q;
    end else begin
      if (enq_ok) wr_d = wr_q + PtrW'(1);
      if (deq_ok) rd_d = rd_q + PtrW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (enq_ok) mem_q[wr_q[AddrW-1:0]] <= data_i;
  end

endmodule

// File: rtl/lane_fifo_bank.sv
// Steers a tagged write stream into per-lane FIFOs, each exposed as a PipeOut server.
// Optional drop counter enabled by defining LANE_FIFO_BANK_DROP_COUNT_EN.
module lane_fifo_bank
  import lane_fifo_bank_pkg::*;
#(
  parameter int unsigned funnelWidth = 8,
  parameter int unsigned width       = 16,
  parameter int unsigned depth       = 4
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic                         enq__ENA,
  input  logic [width-1:0]             enq_v,
  input  logic [LANE_TAG_WIDTH-1:0]    enq_lane,
  output logic                         enq__RDY,
  input  logic                         flush__ENA,
  input  logic [LANE_TAG_WIDTH-1:0]    flush_lane,
  output logic                         flush__RDY,
`ifdef LANE_FIFO_BANK_DROP_COUNT_EN
  output logic [15:0]                  dropCount,
`endif
  output logic [funnelWidth*width-1:0] out_first,
  output logic [funnelWidth-1:0]       out_first__RDY,
  input  logic [funnelWidth-1:0]       out_deq__ENA,
  output logic [funnelWidth-1:0]       out_deq__RDY
);

  logic [funnelWidth-1:0] enq_sel, flush_sel, full, empty;

  assign flush__RDY = 1'b1;

  // Out-of-range lanes leave enq__RDY high so the beat is swallowed.
  always_comb begin
    enq_sel   = '0;
    flush_sel = '0;
    enq__RDY  = 1'b1;
    for (int unsigned i = 0; i < funnelWidth; i++) begin
      if (enq_lane == LANE_TAG_WIDTH'(i)) begin
        enq_sel[i] = enq__ENA;
        enq__RDY   = ~full[i];
      end
      if (flush_lane == LANE_TAG_WIDTH'(i)) flush_sel[i] = flush__ENA;
    end
  end

  for (genvar g = 0; g < funnelWidth; g++) begin : g_lane
    lane_fifo #(
      .width(width),
      .depth(depth)
    ) u_fifo (
      .clk_i  (CLK),
      .rst_i  (RST),
      .enq_i  (enq_sel[g]),
      .data_i (enq_v),
      .deq_i  (out_deq__ENA[g]),
      .flush_i(flush_sel[g]),
      .full_o (full[g]),
      .empty_o(empty[g]),
      .first_o(out_first[g*width +: width])
    );
  end

  assign out_first__RDY = ~empty;
  assign out_deq__RDY   = ~empty;

`ifdef LANE_FIFO_BANK_DROP_COUNT_EN
  logic        drop;
  logic [15:0] drop_cnt_q;

  assign drop = enq__ENA && ((32'(enq_lane) >= funnelWidth) || !enq__RDY);

  always_ff @(posedge CLK) begin
    if (RST) begin
      drop_cnt_q <= '0;
    end else if (drop && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end

  assign dropCount = drop_cnt_q;
`endif

endmodule

// File: doc/lane_fifo_bank.md
# lane_fifo_bank

Per-lane buffering stage that feeds the funnel selector. A single tagged write stream enters, and each beat is steered by its lane tag into one of `funnelWidth` independent FIFOs. Each FIFO is exposed as a `PipeOut` server, and the array of servers connects directly to the `in[]` client array of the downstream selector. This decouples bursty producers from the selector's one-lane-at-a-time draining.

## Interface
Parameters:
- `funnelWidth`, default 8: number of lanes, at most 16.
- `width`, default 16: data width per beat.
- `depth`, default 4: entries per lane FIFO; power of 2, at least 2.

Ports:
- `CLK`, input, 1: the single clock.
- `RST`, input, 1: reset, synchronous and active-high.
- `enq__ENA`, input, 1: write strobe.
- `enq$v`, input, `width`: write data.
- `enq$lane`, input, 4: target lane tag.
- `enq__RDY`, output, 1: write may be accepted this cycle. Combinational in `enq$lane`.
- `flush__ENA`, input, 1: discard the contents of one lane.
- `flush$lane`, input, 4: lane to flush.
- `flush__RDY`, output, 1: constant 1.
- `out[funnelWidth]`, `PipeOut.server`: per-lane `first`, `first__RDY`, `deq__ENA`, `deq__RDY`.

## Operation
- **Per-lane state:**
  - read pointer and write pointer, each log2(depth)+1 bits;
  - storage of `depth` entries × `width` bits.
  - Empty when the pointers are equal. Full when the low bits are equal and the MSBs differ. Pointers wrap modulo 2·depth.
- **`enq__RDY`:**
  - 1 if `enq$lane` ≥ `funnelWidth` (out-of-range write is accepted and discarded);
  - otherwise 1 iff the target lane is not full.
- **Accepted write:** requires `enq__ENA` && `enq__RDY` with an in-range lane. Data goes to the slot at the lane's write pointer, and the write pointer increments. An `enq__ENA` while `enq__RDY` = 0 is a protocol violation; the block ignores it, with no state change.
- **Outputs of lane i:**
  - `first` = storage at the lane's read pointer (contents undefined when empty);
  - `first__RDY` = `deq__RDY` = not empty.
- **Dequeue:** `deq__ENA` on a non-empty lane increments its read pointer. `deq__ENA` on an empty lane is ignored. Multiple lanes may dequeue in the same cycle; the selector only asserts one.
- **Enq and deq on the same lane, same cycle:**
  - both take effect, and occupancy is unchanged;
  - when the lane is full, `enq__RDY` is already 0, so there is no full-lane bypass;
  - there is no empty-lane bypass either, so data is never visible in the cycle it is written.
- **Flush:** `flush__ENA` with an in-range lane sets that lane's read pointer equal to its write pointer. An out-of-range flush is a no-op.
- **Flush coinciding with enq or deq on the same lane:** flush wins, the enq data is lost, and the lane is empty next cycle. Other lanes are unaffected.

## Timing
- Reset (`RST` = 1 at a `CLK` edge): all pointers go to 0. Every `first__RDY`/`deq__RDY` is 0 from the following cycle. `enq__RDY` is 1 for any lane. Storage is not reset. Reset asserted mid-stream discards all buffered data.
- Write-to-visible latency is 1 cycle: a write accepted at edge N gives `first__RDY` = 1 and valid `first` after edge N.
- Dequeue advances `first` at the same edge; the next entry is visible the following cycle.
- A lane sustains 1 beat/cycle of enq and deq concurrently. Full throughput needs `depth` ≥ 2.

## Configuration
- `LANE_FIFO_BANK_DROP_COUNT_EN`, when defined, adds output port `dropCount` (16 bits):
  - counts out-of-range writes discarded, plus `enq__ENA` asserted with `enq__RDY` = 0;
  - saturates at 16'hFFFF;
  - cleared by `RST`.
- When the macro is undefined, the port and the counter are absent and behaviour is otherwise identical.

## Structure
- A shared package holds:
  - the lane-tag typedef (4 bits);
  - the `LANE_TAG_WIDTH` constant;
  - the pointer-width function clog2(depth)+1.
- The block has one sub-module, `lane_fifo`: a single synchronous FIFO with enq, deq, flush, full, empty and first. The top instantiates it `funnelWidth` times in a generate loop and decodes enq and flush per lane.

## Test plan
- **Reset then fill:** reset, then write 0x1111, 0x2222, 0x3333, 0x4444 to lane 2.
  - Lane 2 `first__RDY` = 1 one cycle after the first write, with `first` = 0x1111.
  - After 4 writes, `enq__RDY` is 0 for lane 2 and 1 for lane 3.
- **Concurrent enq/deq:** with lane 5 holding 2 entries, enq and deq each cycle for 10 cycles.
  - Occupancy stays at 2 and data emerges in write order.
- **Full-lane boundary:** with lane 0 full, assert deq and present enq to lane 0.
  - `enq__RDY` = 0 that cycle.
  - The next cycle `enq__RDY` = 1 and occupancy is 3.
- **Out-of-range write:** `enq$lane` = 12 with funnelWidth = 8.
  - `enq__RDY` = 1 and no lane changes.
  - With the macro defined, `dropCount` goes 0→1.
- **Flush vs enq:** with lane 1 holding 3 entries, flush lane 1 and enq lane 1 with 0xABCD in the same cycle.
  - Lane 1 is empty next cycle and 0xABCD is never presented.
- **Reset mid-stream:** with all lanes holding data, assert `RST` for 1 cycle.
  - All `first__RDY` = 0 next cycle, and a subsequent write to lane 7 appears after 1 cycle.
